// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sequencer: state encoding and default duty width.
package glitch_pkg;

   localparam int DEFAULT_DUTY_BITS = 10;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DELAY,
      GLITCH,
      GAP
   } state_e;

endpackage

// File: rtl/trig_edge.sv
// Rising-edge detector for the target trigger. Defining TRIG_SYNC_EN inserts a
// 2-flop synchronizer ahead of the detector.
module trig_edge (
   input  logic clk,
   input  logic rst,
   input  logic trig_i,
   output logic pulse_o
);

   logic detIn;
   logic prev_q;

`ifdef TRIG_SYNC_EN
   logic sync1_q;
   logic sync2_q;

   // Synchronizer resets high so a trigger already asserted never looks like a fresh edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= trig_i;
         sync2_q <= sync1_q;
      end
   end

   assign detIn = sync2_q;
`else
   assign detIn = trig_i;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= detIn;
      end
   end

   assign pulse_o = detIn & ~prev_q;

endmodule

// File: rtl/glitch_sched.sv
// Glitch sequencer driving the PWM duty_cycle input: idle level, then after a trigger
// edge a delay followed by repeated glitch pulses. Optional macro: TRIG_SYNC_EN.
module glitch_sched
   import glitch_pkg::*;
#(
   parameter int DUTY_BITS  = DEFAULT_DUTY_BITS,
   parameter int DELAY_BITS = 24,
   parameter int WIDTH_BITS = 16,
   parameter int COUNT_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DUTY_BITS-1:0]  cfg_idle_duty,
   input  logic [DUTY_BITS-1:0]  cfg_glitch_duty,
   input  logic [DELAY_BITS-1:0] cfg_delay,
   input  logic [WIDTH_BITS-1:0] cfg_width,
   input  logic [WIDTH_BITS-1:0] cfg_gap,
   input  logic [COUNT_BITS-1:0] cfg_count,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  trigger,
   output logic [DUTY_BITS-1:0]  duty_cycle,
   output logic                  armed,
   output logic                  busy,
   output logic                  done
);

   state_e                state_q, state_d;
   logic [DELAY_BITS-1:0] cnt_q, cnt_d;
   logic [COUNT_BITS-1:0] pulses_q, pulses_d;
   logic [DUTY_BITS-1:0]  duty_q, duty_d;
   logic                  done_q, done_d;

   logic [DUTY_BITS-1:0]  idle_q, glitch_q;
   logic [DELAY_BITS-1:0] delay_q;
   logic [WIDTH_BITS-1:0] width_q, gap_q;
   logic [COUNT_BITS-1:0] count_q;

   logic                  trigPulse;
   logic [DELAY_BITS-1:0] delayLoad, widthLoad, gapLoad;
   logic [COUNT_BITS-1:0] countLoad;

   trig_edge u_trig_edge (
      .clk     (clk),
      .rst     (rst),
      .trig_i  (trigger),
      .pulse_o (trigPulse)
   );

   // Counters hold "cycles left minus one" so each phase exits on the zero cycle
   assign delayLoad = delay_q - DELAY_BITS'(1);
   assign widthLoad = (width_q == '0) ? '0 : DELAY_BITS'(width_q - WIDTH_BITS'(1));
   assign gapLoad   = (gap_q == '0) ? '0 : DELAY_BITS'(gap_q - WIDTH_BITS'(1));
   assign countLoad = (count_q == '0) ? COUNT_BITS'(1) : count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pulses_q <= '0;
         duty_q   <= '0;
         done_q   <= 1'b0;
         idle_q   <= '0;
         glitch_q <= '0;
         delay_q  <= '0;
         width_q  <= '0;
         gap_q    <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pulses_q <= pulses_d;
         duty_q   <= duty_d;
         done_q   <= done_d;
         if (state_q == IDLE && arm && !abort) begin
            idle_q   <= cfg_idle_duty;
            glitch_q <= cfg_glitch_duty;
            delay_q  <= cfg_delay;
            width_q  <= cfg_width;
            gap_q    <= cfg_gap;
            count_q  <= cfg_count;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pulses_d = pulses_q;
      done_d   = 1'b0;
      if (abort) begin
         state_d  = IDLE;
         cnt_d    = '0;
         pulses_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (arm) state_d = ARMED;
            end
            ARMED: begin
               if (trigPulse) begin
                  pulses_d = countLoad;
                  if (delay_q == '0) begin
                     state_d = GLITCH;
                     cnt_d   = widthLoad;
                  end else begin
                     state_d = DELAY;
                     cnt_d   = delayLoad;
                  end
               end
            end
            DELAY: begin
               if (cnt_q == '0) begin
                  state_d = GLITCH;
                  cnt_d   = widthLoad;
               end else begin
                  cnt_d = cnt_q - DELAY_BITS'(1);
               end
            end
            GLITCH: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - DELAY_BITS'(1);
               end else if (pulses_q > COUNT_BITS'(1)) begin
                  state_d = GAP;
                  cnt_d   = gapLoad;
               end else begin
                  state_d  = IDLE;
                  pulses_d = '0;
                  done_d   = 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  state_d  = GLITCH;
                  cnt_d    = widthLoad;
                  pulses_d = pulses_q - COUNT_BITS'(1);
               end else begin
                  cnt_d = cnt_q - DELAY_BITS'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Duty is registered from the next state so it lines up with the state it belongs to
   always_comb begin
      duty_d = cfg_idle_duty;
      unique case (state_d)
         IDLE:    duty_d = cfg_idle_duty;
         GLITCH:  duty_d = glitch_q;
         default: duty_d = (state_q == IDLE) ? cfg_idle_duty : idle_q;
      endcase
      armed = (state_q == ARMED);
      busy  = (state_q == DELAY) || (state_q == GLITCH) || (state_q == GAP);
   end

   assign duty_cycle = duty_q;
   assign done       = done_q;

endmodule

// File: doc/glitch_sched.md
Name: glitch_sched

Overview:
- Sequencer that drives the 10-bit duty_cycle input of the PWM DAC block, producing timed voltage-glitch pulses.
- Holds an idle duty level, and waits for arm then a trigger edge.
- After a programmable delay, it switches to a glitch duty for a programmable width, repeated a programmable number of times with gaps, then returns to idle.
- Sits between the host config registers / target trigger input and the PWM block.

Parameters:
DUTY_BITS, 10, width of duty values (matches PWM duty_cycle)
DELAY_BITS, 24, width of trigger-to-first-glitch delay counter
WIDTH_BITS, 16, width of glitch-width and gap counters
COUNT_BITS, 8, width of pulse-repeat counter

Ports:
clk  in  1  system clock, same clock as the PWM block
rst  in  1  synchronous active-high reset
cfg_idle_duty  in  DUTY_BITS  duty when not glitching
cfg_glitch_duty  in  DUTY_BITS  duty during glitch pulse
cfg_delay  in  DELAY_BITS  cycles from trigger edge to first glitch
cfg_width  in  WIDTH_BITS  glitch pulse length in cycles (0 treated as 1)
cfg_gap  in  WIDTH_BITS  idle cycles between pulses (0 treated as 1)
cfg_count  in  COUNT_BITS  number of pulses (0 treated as 1)
arm  in  1  single-cycle request to arm; latches all cfg_*
abort  in  1  return to IDLE immediately
trigger  in  1  target trigger; rising edge fires sequence
duty_cycle  out  DUTY_BITS  registered; connects to PWM duty_cycle
armed  out  1  high in ARMED
busy  out  1  high in DELAY, GLITCH, GAP
done  out  1  one-cycle pulse after last pulse completes

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values: state=IDLE, duty_cycle=0, armed=0, busy=0, done=0, all counters 0, trigger edge history=1 (a trigger already high at reset does not fire).
- States: IDLE, ARMED, DELAY, GLITCH, GAP.
- IDLE
  - duty_cycle <= cfg_idle_duty (live, 1-cycle registered latency).
  - arm=1 latches all cfg_* into shadow registers → ARMED.
  - A trigger in IDLE is ignored and not queued.
- ARMED
  - duty_cycle <= shadow idle.
  - A trigger rising edge (trigger=1, previous sample=0) at cycle T → DELAY with delay counter = shadow delay.
  - A level already high when entering ARMED does not fire; a fresh edge is required.
- DELAY
  - Counter decrements each cycle; at 0 → GLITCH.
  - First cycle of duty_cycle==glitch duty is T+D+1, with D = shadow delay (D=0 gives T+1).
- GLITCH
  - duty_cycle = shadow glitch duty for exactly max(W,1) cycles.
  - Then, if pulses remaining > 1 → GAP; otherwise done pulses on the next cycle → IDLE.
- GAP
  - duty_cycle = shadow idle for max(G,1) cycles → GLITCH; pulses remaining decrements.
- Timing: a total of max(N,1) glitch pulses, with no cycle lost at any transition.
- abort:
  - From any state → IDLE next cycle.
  - duty_cycle = live cfg_idle_duty on that cycle.
  - done not asserted.
  - abort has priority over arm, trigger and counter expiry in the same cycle.
- arm outside IDLE is ignored. cfg_* changes after arm do not affect the running sequence.
- Counters are unsigned; no wrap (they stop at 0 on exit). Max delay 2^DELAY_BITS-1 cycles.
- done and busy never assert in the same cycle.
- rst mid-sequence: same as reset values; duty_cycle=0 the following cycle.

Optional Feature:
TRIG_SYNC_EN
- Defined: trigger passes through a 2-flop synchronizer before edge detection. T is the cycle the edge reaches the detector, 2 cycles after the pin edge, so pin-to-glitch latency = D+3 cycles.
- Undefined: trigger is treated as synchronous to clk; edge detection is applied directly, and pin-to-glitch latency = D+1 cycles.

Decomposition:
- Package glitch_pkg: state enum (IDLE, ARMED, DELAY, GLITCH, GAP) and the default DUTY_BITS constant.
- One sub-module, trig_edge: optional synchronizer plus rising-edge detector, with reset history=1. It outputs a single-cycle pulse.

Test Plan:
- Sequence timing: idle=100, glitch=0, D=5, W=3, N=1; arm, then trigger edge at T → duty 0 on cycles T+6..T+8, duty 100 from T+9, done=1 at T+9 only.
- Repeat and gap: N=3, W=2, G=4, D=0 → glitch duty on T+1..2, T+7..8, T+13..14; done at T+15; busy=1 over T+1..T+14.
- Zero values: W=0, G=0, N=0 → single 1-cycle pulse, identical to W=1, N=1.
- Abort mid-pulse: abort during second GLITCH cycle → next cycle state IDLE, duty=live idle, done never asserts; a subsequent trigger is ignored.
- Stuck-high trigger: trigger held high before and through arm → no fire; low-then-high → fires. Trigger in IDLE then arm → no fire.
- TRIG_SYNC_EN build: repeat scenario 1 → glitch starts at pin-edge cycle + 8; rst asserted mid-DELAY → duty_cycle=0, armed=busy=0 next cycle.
